// File: rtl/da_lut_loader.sv
// Distributed-arithmetic LUT builder: walks each 8-tap group in Gray order with one accumulator and streams 2048 entries to the filter.
// Optional build macro DA_LOAD_CHECKSUM_EN adds a 32-bit checksum output (csum) of all written entries.
module da_lut_loader #(
    parameter int WR_GAP = 192
) (
    input  logic               clk_fast,
    input  logic               reset,
    input  logic               coef_wr,
    input  logic [5:0]         coef_addr,
    input  logic [15:0]        coef_data,
    input  logic               start,
    output logic signed [18:0] CIN,
    output logic [10:0]        CADDR,
    output logic               CLOAD,
    output logic               lut_we,
    output logic               busy,
    output logic               done,
    output logic               filt_en,
`ifdef DA_LOAD_CHECKSUM_EN
    output logic               coef_err,
    output logic [31:0]        csum
`else
    output logic               coef_err
`endif
);

    typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;

    state_t             state, state_nxt;
    logic signed [15:0] coef [64];
    logic [9:0]         gap;
    logic [2:0]         grp;
    logic [7:0]         n;
    logic [7:0]         pat;
    logic signed [18:0] acc;
    logic               loaded;

    logic               step_due;
    logic               last_wr;
    logic [7:0]         n_nxt;
    logic [2:0]         bsel;
    logic signed [15:0] coef_sel;
    logic signed [18:0] coef_ext;
    logic signed [18:0] acc_step;

    // Gray step n flips the bit at the trailing-zero position of n
    always_comb begin
        step_due = (gap == 10'(WR_GAP - 1));
        last_wr  = (grp == 3'd7) && (n == 8'd255);
        n_nxt    = n + 8'd1;
        bsel     = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (n_nxt[i]) bsel = 3'(i);
        coef_sel = coef[{grp, bsel}];
        coef_ext = {{3{coef_sel[15]}}, coef_sel};
        acc_step = pat[bsel] ? (acc - coef_ext) : (acc + coef_ext);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUILD;
            BUILD:   if (step_due && last_wr) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_fast) begin
        if (reset) begin
            state    <= IDLE;
            gap      <= '0;
            grp      <= '0;
            n        <= '0;
            pat      <= '0;
            acc      <= '0;
            lut_we   <= 1'b0;
            loaded   <= 1'b0;
            coef_err <= 1'b0;
            for (int i = 0; i < 64; i++) coef[i] <= '0;
        end else begin
            state  <= state_nxt;
            lut_we <= 1'b0;
            if (coef_wr) begin
                if (state == IDLE) coef[coef_addr] <= coef_data;
                else               coef_err <= 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    // entry 0 of group 0 is always zero, so it goes out immediately
                    acc    <= '0;
                    grp    <= '0;
                    n      <= '0;
                    pat    <= '0;
                    gap    <= '0;
                    lut_we <= 1'b1;
                    loaded <= 1'b0;
                end
                BUILD: if (step_due) begin
                    gap <= '0;
                    if (!last_wr) begin
                        lut_we <= 1'b1;
                        if (n == 8'd255) begin
                            grp <= grp + 3'd1;
                            n   <= '0;
                            pat <= '0;
                            acc <= '0;
                        end else begin
                            n   <= n_nxt;
                            pat <= pat ^ (8'd1 << bsel);
                            acc <= acc_step;
                        end
                    end
                end else begin
                    gap <= gap + 10'd1;
                end
                DONE: loaded <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef DA_LOAD_CHECKSUM_EN
    always_ff @(posedge clk_fast) begin
        if (reset)
            csum <= '0;
        else if (state == IDLE && start)
            csum <= '0;
        else if (lut_we)
            csum <= csum + {{13{acc[18]}}, acc};
    end
`endif

    assign CIN     = acc;
    assign CADDR   = {grp, pat};
    assign busy    = (state == BUILD);
    assign CLOAD   = (state == BUILD);
    assign done    = (state == DONE);
    assign filt_en = loaded && (state == IDLE);

endmodule

// File: doc/da_lut_loader.md
DA_LUT_LOADER -- requirements
Module: da_lut_loader

Interface
REQ-001 Parameter WR_GAP, default 192, clk_fast cycles between consecutive LUT writes (legal range 1..1023).
REQ-002 clk_fast  in  1  sole clock; all logic on its rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 coef_wr  in  1  coefficient write strobe, sampled each cycle.
REQ-005 coef_addr  in  6  tap index 0..63.
REQ-006 coef_data  in  16  signed tap coefficient.
REQ-007 start  in  1  single-cycle request to build and load the full LUT.
REQ-008 CIN  out  19  signed LUT entry value to the filter.
REQ-009 CADDR  out  11  LUT entry address {group[2:0], pattern[7:0]}.
REQ-010 CLOAD  out  1  high for the whole load sequence.
REQ-011 lut_we  out  1  one-cycle strobe; CIN/CADDR valid in the same cycle.
REQ-012 busy  out  1  high while in BUILD.
REQ-013 done  out  1  one-cycle pulse after the last LUT write.
REQ-014 filt_en  out  1  drives the filter valid_in; high only when a complete LUT is loaded.
REQ-015 coef_err  out  1  sticky; set by a coef_wr while busy.

Function
REQ-016 Internal store: 64 x 16-bit signed coefficient registers; coef_wr in IDLE writes coef_data to coef[coef_addr] at the next edge.
REQ-017 FSM states: IDLE, BUILD, DONE; IDLE->BUILD on start; BUILD->DONE after write 2048; DONE->IDLE unconditionally after one cycle.
REQ-018 Entry value: LUT[g*256+p] = sum of coef[g*8+b] over every bit b set in p; LUT[g*256+0] = 0.
REQ-019 Within each group, patterns visited in Gray order p(n) = n ^ (n>>1), n = 0..255; groups visited 0..7.
REQ-020 Single 19-bit signed accumulator: step n flips bit b = trailing-zero count of n; add coef[g*8+b] if bit b becomes 1, subtract if it becomes 0.
REQ-021 Accumulator cleared to 0 at entry to each group; no saturation required (8 x 16-bit signed always fits 19 bits).
REQ-022 First lut_we in the cycle after start is sampled; subsequent lut_we exactly WR_GAP cycles apart; total exactly 2048 strobes.
REQ-023 CIN and CADDR held stable between strobes at the last written values.
REQ-024 CLOAD rises with the cycle of the first lut_we and falls in the DONE cycle; done pulses in the DONE cycle.
REQ-025 filt_en low from start sampling through BUILD and DONE; high from the cycle after DONE until the next start or reset.
REQ-026 start while BUILD or DONE is ignored; start with coef_wr in the same IDLE cycle: write takes effect and the build uses the new value.
REQ-027 coef_wr during BUILD/DONE is discarded and sets coef_err; coef_err clears only on reset.

Reset
REQ-028 reset in any state returns to IDLE at the next edge, aborting any build with no further lut_we.
REQ-029 Reset values: CIN=0, CADDR=0, CLOAD=0, lut_we=0, busy=0, done=0, filt_en=0, coef_err=0, accumulator=0, all coef registers=0.

Configuration
REQ-030 Macro DA_LOAD_CHECKSUM_EN: when defined, add output csum (32 bits), cleared at start, adding sign-extended CIN on every lut_we, stable after done.
REQ-031 Without DA_LOAD_CHECKSUM_EN the csum port and its logic do not exist; all other behaviour identical.

Verification
REQ-032 All coef=0, start, WR_GAP=4 -> 2048 lut_we 4 cycles apart, every CIN=0, done once 4 cycles after last strobe window, filt_en then high.
REQ-033 coef[0]=100, coef[1]=-7, others 0, start -> LUT[1]=100, LUT[2]=-7, LUT[3]=93, LUT[256..2047]=0; CADDR sequence begins 0,1,3,2.
REQ-034 All 64 coef=-32768, start -> LUT[g*256+255]=-262144 (19-bit 0x40000) for every g, no wrap.
REQ-035 Random coefficients, start -> each CIN matches REQ-018 reference model; with DA_LOAD_CHECKSUM_EN csum equals the model's sum of all 2048 entries.
REQ-036 reset asserted after write 500 -> next cycle CLOAD=0, busy=0, filt_en=0, no lut_we; subsequent start restarts at CADDR=0.
REQ-037 coef_wr during BUILD and start during BUILD -> coef unchanged, coef_err=1, build completes with exactly 2048 writes.
